// File: rtl/fork_any_join_ctrl_pkg.sv
// fork_any_pkg: shared FSM state enum, branch identifier type and default counter width for fork_any_join_ctrl
package fork_any_pkg;
    localparam int CNT_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, RUN_BOTH, RUN_ONE} state_t;
    typedef enum logic {BR_A = 1'b0, BR_B = 1'b1} branch_id_t;
endpackage

// File: rtl/fork_any_join_ctrl_if.sv
// fork_any_join_ctrl_if: launch handshake (start_valid/ready, dur_a/b), branch status (busy, done_a/b, any_done, all_done, first_id, tie, join_time) and downstream handoff (next_valid/ready); master = launcher/consumer side, slave = controller
interface fork_any_join_ctrl_if #(parameter int CNT_W = fork_any_pkg::CNT_W_DEF);
    logic start_valid;
    logic start_ready;
    logic [CNT_W-1:0] dur_a;
    logic [CNT_W-1:0] dur_b;
    logic busy;
    logic done_a;
    logic done_b;
    logic any_done;
    logic first_id;
    logic tie;
    logic [CNT_W-1:0] join_time;
    logic all_done;
    logic next_valid;
    logic next_ready;
    modport master (
        output start_valid, dur_a, dur_b, next_ready,
        input start_ready, busy, done_a, done_b, any_done, first_id, tie, join_time, all_done, next_valid
    );
    modport slave (
        input start_valid, dur_a, dur_b, next_ready,
        output start_ready, busy, done_a, done_b, any_done, first_id, tie, join_time, all_done, next_valid
    );
endinterface

// File: rtl/fork_any_join_ctrl_branch_timer.sv
// branch_timer: loads max(dur,1) on load, counts down, raises fin combinationally on the final count, registered one-cycle done pulse, running while counting
module branch_timer import fork_any_pkg::*; #(parameter int CNT_W = CNT_W_DEF) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] dur,
    output logic             done,
    output logic             running,
    output logic             fin
);
    logic [CNT_W-1:0] cnt;
    assign fin = running && cnt == CNT_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            running <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                cnt <= dur == '0 ? CNT_W'(1) : dur;
                running <= 1'b1;
            end else if (running) begin
                cnt <= cnt - CNT_W'(1);
                running <= !fin;
            end
        end
    end
endmodule

// File: rtl/fork_any_join_ctrl.sv
// fork_any_join_ctrl: launches timers A/B on accept, pulses any_done on first completion (join-any) with captured first_id/tie/join_time, all_done on last, and holds next_valid until next_ready; ports clk, rst, bus (slave)
module fork_any_join_ctrl import fork_any_pkg::*; #(parameter int CNT_W = CNT_W_DEF) (
    input logic                 clk,
    input logic                 rst,
    fork_any_join_ctrl_if.slave bus
);
    state_t state, state_nxt;
    branch_id_t first_id;
    logic fin_a, fin_b, run_a, run_b, accept, first, last;
    logic any_done, all_done, next_valid, tie;
    logic [CNT_W-1:0] elapsed, join_time;
    assign bus.start_ready = state == IDLE && !next_valid;
    assign bus.busy = state != IDLE;
    assign bus.any_done = any_done;
    assign bus.all_done = all_done;
    assign bus.next_valid = next_valid;
    assign bus.first_id = first_id;
    assign bus.tie = tie;
    assign bus.join_time = join_time;
    assign accept = bus.start_valid && bus.start_ready;
    assign first = state == RUN_BOTH && (fin_a || fin_b);
    // In RUN_ONE only the still-running branch can finish
    assign last = (state == RUN_BOTH && fin_a && fin_b) || (state == RUN_ONE && ((run_a && fin_a) || (run_b && fin_b)));
    branch_timer #(.CNT_W(CNT_W)) u_a (.clk(clk), .rst(rst), .load(accept), .dur(bus.dur_a), .done(bus.done_a), .running(run_a), .fin(fin_a));
    branch_timer #(.CNT_W(CNT_W)) u_b (.clk(clk), .rst(rst), .load(accept), .dur(bus.dur_b), .done(bus.done_b), .running(run_b), .fin(fin_b));
    always_comb begin
        state_nxt = state;
        state_nxt = accept ? RUN_BOTH : last ? IDLE : first ? RUN_ONE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            any_done <= 1'b0;
            all_done <= 1'b0;
            next_valid <= 1'b0;
            first_id <= BR_A;
            tie <= 1'b0;
            join_time <= '0;
            elapsed <= '0;
        end else begin
            state <= state_nxt;
            any_done <= first;
            all_done <= last;
            next_valid <= first || (next_valid && !bus.next_ready);
            elapsed <= accept ? '0 : state != IDLE ? elapsed + CNT_W'(1) : elapsed;
            if (first) begin
                first_id <= fin_a ? BR_A : BR_B;
                tie <= fin_a && fin_b;
                join_time <= elapsed + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fork_any_join_ctrl.sv
// tb_fork_any_join_ctrl: directed scenarios plus randomized traffic checked against an event-time reference model
module tb_fork_any_join_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    bit m_act = 0;
    bit m_nv = 0;
    int m_l = 0;
    int m_ea = 1;
    int m_eb = 1;
    int m_first = 0;
    int m_tie = 0;
    int m_jt = 0;
    fork_any_join_ctrl_if #(.CNT_W(W)) bus ();
    fork_any_join_ctrl #(.CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic int mn();
        return m_ea < m_eb ? m_ea : m_eb;
    endfunction
    function automatic int mx();
        return m_ea > m_eb ? m_ea : m_eb;
    endfunction
    function automatic bit m_busy();
        return m_act && cyc >= m_l && cyc < m_l + mx();
    endfunction
    function automatic bit m_ready();
        return !m_busy() && !m_nv;
    endfunction

    task automatic step();
        bit acc, hs;
        int da, db;
        acc = bus.start_valid && m_ready();
        hs = m_nv && bus.next_ready;
        da = bus.dur_a == 0 ? 1 : int'(bus.dur_a);
        db = bus.dur_b == 0 ? 1 : int'(bus.dur_b);
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_act = 0; m_nv = 0; m_first = 0; m_tie = 0; m_jt = 0;
        end else begin
            if (hs) m_nv = 0;
            if (acc) begin
                m_act = 1; m_l = cyc; m_ea = da; m_eb = db;
            end
            if (m_act && cyc == m_l + mn()) begin
                m_nv = 1; m_first = int'(m_eb < m_ea); m_tie = int'(m_ea == m_eb); m_jt = mn();
            end
        end
        @(negedge clk);
    endtask

    task automatic launch(input int a, input int b);
        bus.dur_a = W'(a);
        bus.dur_b = W'(b);
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic settle();
        bus.start_valid = 1'b0;
        bus.next_ready = 1'b1;
        for (int i = 0; i < 300 && !m_ready(); i++) step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (bus.start_ready !== 1'b1) begin fails++; $display("FAIL reset start_ready got %b want 1", bus.start_ready); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", bus.busy); end
        tests++; if (bus.next_valid !== 1'b0) begin fails++; $display("FAIL reset next_valid got %b want 0", bus.next_valid); end
        tests++; if ({bus.done_a, bus.done_b, bus.any_done, bus.all_done} !== 4'b0) begin fails++; $display("FAIL reset pulses got %b want 0000", {bus.done_a, bus.done_b, bus.any_done, bus.all_done}); end
        tests++; if ({bus.first_id, bus.tie, bus.join_time} !== '0) begin fails++; $display("FAIL reset capture got id=%b tie=%b jt=%0d want 0/0/0", bus.first_id, bus.tie, bus.join_time); end
    endtask

    task automatic test_a_slower();
        int t_any = -1, t_da = -1, t_db = -1, t_all = -1, n_any = 0, nvc = 0;
        logic fid = 1'b0;
        logic [W-1:0] jt = '0;
        bus.next_ready = 1'b1;
        launch(20, 10);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL slow_accept busy got %b want 1", bus.busy); end
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.any_done === 1'b1) begin n_any++; t_any = cyc - t0; fid = bus.first_id; jt = bus.join_time; end
            if (bus.done_a === 1'b1) t_da = cyc - t0;
            if (bus.done_b === 1'b1) t_db = cyc - t0;
            if (bus.all_done === 1'b1) t_all = cyc - t0;
            if (bus.next_valid === 1'b1) nvc++;
        end
        tests++; if (t_db != 10) begin fails++; $display("FAIL slow_done_b at %0d want 10", t_db); end
        tests++; if (t_any != 10 || n_any != 1) begin fails++; $display("FAIL slow_any at %0d count %0d want 10/1", t_any, n_any); end
        tests++; if (fid !== 1'b1) begin fails++; $display("FAIL slow_first_id got %b want 1", fid); end
        tests++; if (jt !== 8'd10) begin fails++; $display("FAIL slow_join_time got %0d want 10", jt); end
        tests++; if (t_da != 20 || t_all != 20) begin fails++; $display("FAIL slow_done_a/all at %0d/%0d want 20/20", t_da, t_all); end
        tests++; if (nvc != 1) begin fails++; $display("FAIL slow_next_valid_len got %0d want 1", nvc); end
        settle();
    endtask

    task automatic test_tie();
        int t_any = -1, t_all = -1, n_any = 0, n_all = 0;
        logic fid = 1'b1, tv = 1'b0;
        bus.next_ready = 1'b1;
        launch(5, 5);
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.any_done === 1'b1) begin n_any++; t_any = cyc - t0; fid = bus.first_id; tv = bus.tie; end
            if (bus.all_done === 1'b1) begin n_all++; t_all = cyc - t0; end
        end
        tests++; if (t_any != 5 || n_any != 1) begin fails++; $display("FAIL tie_any at %0d count %0d want 5/1", t_any, n_any); end
        tests++; if (tv !== 1'b1 || fid !== 1'b0) begin fails++; $display("FAIL tie_flags tie=%b id=%b want 1/0", tv, fid); end
        tests++; if (t_all != 5 || n_all != 1) begin fails++; $display("FAIL tie_all at %0d count %0d want 5/1", t_all, n_all); end
        settle();
    endtask

    task automatic test_zero();
        int t_any = -1, t_da = -1, t_db = -1, t_all = -1;
        logic fid = 1'b1;
        logic [W-1:0] jt = '0;
        bus.next_ready = 1'b1;
        launch(0, 3);
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.any_done === 1'b1) begin t_any = cyc - t0; fid = bus.first_id; jt = bus.join_time; end
            if (bus.done_a === 1'b1) t_da = cyc - t0;
            if (bus.done_b === 1'b1) t_db = cyc - t0;
            if (bus.all_done === 1'b1) t_all = cyc - t0;
        end
        tests++; if (t_da != 1 || t_any != 1) begin fails++; $display("FAIL zero_first done_a %0d any %0d want 1/1", t_da, t_any); end
        tests++; if (fid !== 1'b0 || jt !== 8'd1) begin fails++; $display("FAIL zero_capture id=%b jt=%0d want 0/1", fid, jt); end
        tests++; if (t_db != 3 || t_all != 3) begin fails++; $display("FAIL zero_last done_b %0d all %0d want 3/3", t_db, t_all); end
        settle();
    endtask

    task automatic test_handoff();
        int t_all = -1, bad_ready = 0, bad_busy = 0, rel;
        bus.next_ready = 1'b0;
        launch(4, 8);
        for (int i = 0; i < 30; i++) begin
            rel = cyc - t0;
            bus.start_valid = rel == 11;
            if (rel == 11) begin bus.dur_a = 8'd2; bus.dur_b = 8'd2; end
            bus.next_ready = rel == 29;
            step();
            rel = cyc - t0;
            if (bus.all_done === 1'b1) t_all = rel;
            if (rel >= 8 && rel <= 29 && bus.start_ready !== 1'b0) bad_ready++;
            if (rel >= 9 && bus.busy !== 1'b0) bad_busy++;
        end
        tests++; if (t_all != 8) begin fails++; $display("FAIL handoff_all at %0d want 8", t_all); end
        tests++; if (bad_ready != 0) begin fails++; $display("FAIL handoff_ready_held %0d cycles with start_ready high want 0", bad_ready); end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL handoff_ignored_launch %0d busy cycles want 0", bad_busy); end
        tests++; if (bus.next_valid !== 1'b0 || bus.start_ready !== 1'b1) begin fails++; $display("FAIL handoff_release nv=%b ready=%b want 0/1", bus.next_valid, bus.start_ready); end
        settle();
    endtask

    task automatic test_reset_mid();
        int n_any = 0, n_all = 0, n_da = 0, n_db = 0, t_any = -1, t_all = -1;
        bus.next_ready = 1'b1;
        launch(10, 20);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1 || bus.next_valid !== 1'b0) begin fails++; $display("FAIL midrst_state busy=%b ready=%b nv=%b want 0/1/0", bus.busy, bus.start_ready, bus.next_valid); end
        launch(3, 2);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL midrst_relaunch busy got %b want 1", bus.busy); end
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.any_done === 1'b1) begin n_any++; t_any = cyc - t0; end
            if (bus.all_done === 1'b1) begin n_all++; t_all = cyc - t0; end
            n_da += int'(bus.done_a === 1'b1);
            n_db += int'(bus.done_b === 1'b1);
        end
        tests++; if (n_any != 1 || t_any != 2) begin fails++; $display("FAIL midrst_any count %0d at %0d want 1/2", n_any, t_any); end
        tests++; if (n_all != 1 || t_all != 3) begin fails++; $display("FAIL midrst_all count %0d at %0d want 1/3", n_all, t_all); end
        tests++; if (n_da != 1 || n_db != 1) begin fails++; $display("FAIL midrst_done counts a=%0d b=%0d want 1/1", n_da, n_db); end
        settle();
    endtask

    task automatic test_back_to_back();
        int q[$];
        bit r4 = 0, b5 = 0;
        bus.next_ready = 1'b1;
        launch(3, 3);
        bus.start_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.any_done === 1'b1) q.push_back(cyc - t0);
            if (cyc - t0 == 4) r4 = bus.start_ready;
            if (cyc - t0 == 5) b5 = bus.busy;
        end
        tests++; if (r4 !== 1'b1 || b5 !== 1'b1) begin fails++; $display("FAIL b2b_relaunch ready@4=%b busy@5=%b want 1/1", r4, b5); end
        tests++; if (q.size() < 3 || q[0] != 3 || q[1] != 8 || q[2] != 13) begin fails++; $display("FAIL b2b_any_times got %p want 3,8,13,...", q); end
        settle();
    endtask

    task automatic test_random(input int n, input int pv, input int pr);
        bit e_da, e_db, e_any, e_all;
        for (int i = 0; i < n; i++) begin
            bus.start_valid = $urandom_range(99) < pv;
            bus.next_ready = $urandom_range(99) < pr;
            bus.dur_a = W'($urandom_range(3) == 0 ? $urandom_range(40) : $urandom_range(6));
            bus.dur_b = W'($urandom_range(3) == 0 ? $urandom_range(40) : $urandom_range(6));
            rst = $urandom_range(299) == 0;
            step();
            rst = 1'b0;
            e_da = m_act && cyc == m_l + m_ea;
            e_db = m_act && cyc == m_l + m_eb;
            e_any = m_act && cyc == m_l + mn();
            e_all = m_act && cyc == m_l + mx();
            tests++; if (bus.start_ready !== m_ready()) begin fails++; $display("FAIL rnd_start_ready cyc %0d got %b want %b", cyc, bus.start_ready, m_ready()); end
            tests++; if (bus.busy !== m_busy()) begin fails++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, bus.busy, m_busy()); end
            tests++; if ({bus.done_a, bus.done_b} !== {e_da, e_db}) begin fails++; $display("FAIL rnd_done cyc %0d got %b%b want %b%b", cyc, bus.done_a, bus.done_b, e_da, e_db); end
            tests++; if ({bus.any_done, bus.all_done} !== {e_any, e_all}) begin fails++; $display("FAIL rnd_any_all cyc %0d got %b%b want %b%b", cyc, bus.any_done, bus.all_done, e_any, e_all); end
            tests++; if (bus.next_valid !== m_nv) begin fails++; $display("FAIL rnd_next_valid cyc %0d got %b want %b", cyc, bus.next_valid, m_nv); end
            if (m_nv) begin
                tests++;
                if (bus.first_id !== m_first[0] || bus.tie !== m_tie[0] || int'(bus.join_time) != m_jt) begin
                    fails++; $display("FAIL rnd_capture cyc %0d got id=%b tie=%b jt=%0d want %0d/%0d/%0d", cyc, bus.first_id, bus.tie, bus.join_time, m_first, m_tie, m_jt);
                end
            end
        end
        rst = 1'b0;
        settle();
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.next_ready = 1'b0;
        bus.dur_a = '0;
        bus.dur_b = '0;
        @(negedge clk);
        test_reset();
        test_a_slower();
        test_tie();
        test_zero();
        test_handoff();
        test_reset_mid();
        test_back_to_back();
        test_random(3000, 40, 50);
        test_random(1500, 90, 90);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fork_any_join_ctrl.md
# fork_any_join_ctrl

Synthesizable two-branch launch/join controller: one accepted start launches timer branches A and B concurrently and releases the downstream stage as soon as either branch completes (join-any), while the slower branch keeps running to completion. Sits directly upstream of the follow-on stage: it produces the "first branch finished" handoff that stage consumes, and reports full completion separately.

## Interface
- `CNT_W`, 8, width of branch durations and of the captured join time
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start_valid`  in  1  request to launch both branches
- `start_ready`  out  1  controller can accept a launch
- `dur_a`  in  CNT_W  branch A duration in cycles, sampled on accept
- `dur_b`  in  CNT_W  branch B duration in cycles, sampled on accept
- `busy`  out  1  at least one branch running
- `done_a` / `done_b`  out  1  one-cycle completion pulse per branch
- `any_done`  out  1  one-cycle join-any pulse (first completion)
- `first_id`  out  1  0 = A, 1 = B; valid while `any_done` or `next_valid`
- `tie`  out  1  both branches finished in the same cycle; qualifies `first_id`
- `join_time`  out  CNT_W  cycles from accept to join-any; valid with `first_id`
- `all_done`  out  1  one-cycle pulse when the last branch completes
- `next_valid`  out  1  handoff to downstream stage pending
- `next_ready`  in  1  downstream stage accepts handoff

## Operation
- Accept = `start_valid && start_ready` at edge E0. `start_ready` = state IDLE and `!next_valid`.
- States: IDLE -> RUN_BOTH on accept; RUN_BOTH -> RUN_ONE when exactly one branch completes; RUN_BOTH -> IDLE when both complete together; RUN_ONE -> IDLE when the remaining branch completes.
- Effective duration = `max(dur, 1)`; a duration of 0 behaves as 1.
- `done_x` high for the one cycle following edge E(dur_x).
- `any_done` coincides with the first `done_a`/`done_b` pulse, once per launch; `first_id` and `join_time` are captured and held until the next accept.
- Tie: both done the same cycle -> single `any_done`, `first_id`=0, `tie`=1, `all_done` in the same cycle.
- `all_done` coincides with the last `done_x` pulse.
- `next_valid` rises with `any_done` and holds until `next_ready` is sampled high. `next_ready` while `next_valid`=0 is ignored.
- `busy` = state != IDLE.
- Launch request while busy or while handoff pending: not accepted; no `start_ready`, inputs ignored.
- No wrap: durations fit CNT_W and `join_time` never exceeds 2^CNT_W-1.

## Timing
- Reset values: state IDLE, all pulses 0, `busy`=0, `next_valid`=0, `first_id`=0, `tie`=0, `join_time`=0, `start_ready`=1 in the cycle after reset.
- Reset mid-operation: counters cleared, no `done_*`/`any_done`/`all_done` pulse in any later cycle for that launch; pending handoff dropped.
- All outputs registered; `start_ready` may be decoded combinationally from registered state.
- Earliest relaunch: the cycle after `all_done` if the handoff was already taken; otherwise the cycle after the `next_ready` handshake.
- `next_ready` in the same cycle `any_done` rises: handshake completes at the next edge; `next_valid` is high for exactly one cycle.

## Structure
- Package `fork_any_pkg`: state enum (IDLE, RUN_BOTH, RUN_ONE), `branch_id_t` (A=0, B=1), and the CNT_W default.
- Sub-module `branch_timer`: load/duration in, down-counter, one-cycle `done` pulse, `running` out. It is instantiated twice; the FSM, join logic and handoff register live in the top.

## Test plan
- dur_a=20, dur_b=10, accept at cycle 0 -> done_b and any_done at cycle 10, first_id=1, join_time=10; done_a and all_done at cycle 20; next_ready held high -> next_valid high one cycle only.
- dur_a=5, dur_b=5 -> single any_done at 5, tie=1, first_id=0, all_done at 5.
- dur_a=0, dur_b=3 -> done_a and any_done at 1 (first_id=0), all_done at 3.
- next_ready held low until cycle 30 with dur 4/8 -> start_ready stays 0 after all_done at 8 until the handshake at 30; start_valid at cycle 12 is not accepted.
- rst asserted at cycle 6 of a 10/20 launch -> no further pulses, all outputs at reset values at cycle 7, and a new launch is accepted at cycle 7.
